// File: rtl/spi_flash_arbiter_pkg.sv
// spi_flash_arbiter_pkg: shared FSM encodings, owner ids and flash command constants
package spi_flash_arbiter_pkg;
  localparam logic [2:0] GUARD   = 3'd0;
  localparam logic [2:0] IDLE    = 3'd1;
  localparam logic [2:0] OWN     = 3'd2;
  localparam logic [2:0] WAIT_HI = 3'd3;
  localparam logic [2:0] WAIT_LO = 3'd4;
  localparam logic OWNER_R0 = 1'b0;
  localparam logic OWNER_R1 = 1'b1;
  localparam logic [7:0] FAST_READ = 8'h0B;
endpackage

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: round-robin transaction arbiter sharing one SPI byte engine and flash cs
module spi_flash_arbiter
  import spi_flash_arbiter_pkg::*;
#(
  parameter int CS_HIGH_MIN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_req,
  output logic       r0_gnt,
  input  logic       r0_start,
  input  logic [7:0] r0_din,
  output logic       r0_busy,
  output logic       r0_done,
  input  logic       r1_req,
  output logic       r1_gnt,
  input  logic       r1_start,
  input  logic [7:0] r1_din,
  output logic       r1_busy,
  output logic       r1_done,
  output logic [7:0] rx_data,
  output logic       spi_start,
  output logic [7:0] spi_din,
  input  logic       spi_busy,
  input  logic [7:0] spi_dout,
  output logic       cs
);
  localparam logic [7:0] CSH = 8'(CS_HIGH_MIN);
  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d, sdin_q, sdin_d, rx_q, rx_d;
  logic       owner_q, owner_d, last_q, last_d, cs_q, cs_d, start_q, start_d;
  logic [1:0] gnt_q, gnt_d, busy_q, busy_d, done_q, done_d;
  logic       own_req, own_start, nxt;
  logic [7:0] own_din;
  assign own_req   = owner_q ? r1_req : r0_req;
  assign own_start = owner_q ? r1_start : r0_start;
  assign own_din   = owner_q ? r1_din : r0_din;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sdin_d  = sdin_q;
    rx_d    = rx_q;
    owner_d = owner_q;
    last_d  = last_q;
    cs_d    = cs_q;
    start_d = start_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    done_d  = 2'b00;
    nxt     = (r0_req & r1_req) ? ~last_q : r1_req;
    case (state_q)
      GUARD: begin
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q <= 8'd1) ? IDLE : GUARD;
      end
      IDLE: if (r0_req | r1_req) begin
        owner_d = nxt;
        last_d  = nxt;
        cs_d    = 1'b0;
        gnt_d   = (nxt == OWNER_R1) ? 2'b10 : 2'b01;
        state_d = OWN;
      end
      OWN: if (!own_req) begin
        gnt_d   = 2'b00;
        cs_d    = 1'b1;
        cnt_d   = CSH;
        state_d = GUARD;
      end else if (own_start) begin
        sdin_d          = own_din;
        start_d         = 1'b1;
        busy_d[owner_q] = 1'b1;
        state_d         = WAIT_HI;
      end
      WAIT_HI: if (spi_busy) begin
        start_d = 1'b0;
        state_d = WAIT_LO;
      end
      WAIT_LO: if (!spi_busy) begin
        rx_d            = spi_dout;
        done_d[owner_q] = 1'b1;
        busy_d[owner_q] = 1'b0;
        state_d         = OWN;
      end
      default: state_d = GUARD;
    endcase
  end
  // last_q resets to R1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GUARD;
      cnt_q   <= CSH;
      sdin_q  <= 8'h00;
      rx_q    <= 8'h00;
      owner_q <= OWNER_R0;
      last_q  <= OWNER_R1;
      cs_q    <= 1'b1;
      start_q <= 1'b0;
      gnt_q   <= 2'b00;
      busy_q  <= 2'b00;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sdin_q  <= sdin_d;
      rx_q    <= rx_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cs_q    <= cs_d;
      start_q <= start_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign r0_gnt    = gnt_q[0];
  assign r1_gnt    = gnt_q[1];
  assign r0_busy   = busy_q[0];
  assign r1_busy   = busy_q[1];
  assign r0_done   = done_q[0];
  assign r1_done   = done_q[1];
  assign rx_data   = rx_q;
  assign spi_start = start_q;
  assign spi_din   = sdin_q;
  assign cs        = cs_q;
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb_spi_flash_arbiter: scoreboard bench with engine model and rule-level arbitration reference
module tb_spi_flash_arbiter;
  import spi_flash_arbiter_pkg::*;
  localparam int CSH = 4;
  logic       clk, rst;
  logic [1:0] req, start, gnt, busy, done;
  logic [7:0] din [2];
  logic [7:0] rx_data, spi_din, spi_dout;
  logic       spi_start, spi_busy, cs;
  int checks = 0, passes = 0, acc_cnt = 0, done_cnt = 0;
  logic [8:0] exp_spi [$];
  logic [8:0] exp_rx [$];
  bit         gnt_log [$];
  bit         fixed_rx = 0;

  spi_flash_arbiter #(.CS_HIGH_MIN(CSH)) dut (
    .clk(clk), .rst(rst),
    .r0_req(req[0]), .r0_gnt(gnt[0]), .r0_start(start[0]), .r0_din(din[0]),
    .r0_busy(busy[0]), .r0_done(done[0]),
    .r1_req(req[1]), .r1_gnt(gnt[1]), .r1_start(start[1]), .r1_din(din[1]),
    .r1_busy(busy[1]), .r1_done(done[1]),
    .rx_data(rx_data), .spi_start(spi_start), .spi_din(spi_din),
    .spi_busy(spi_busy), .spi_dout(spi_dout), .cs(cs)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // engine model: accepts a start when idle, stays busy 2..5 cycles, then presents a byte
  logic       eng_busy;
  logic [2:0] eng_cnt;
  logic [7:0] eng_val;
  logic [8:0] eng_e;
  assign spi_busy = eng_busy;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_busy <= 1'b0;
      eng_cnt  <= 3'd0;
      spi_dout <= 8'h00;
    end else if (!eng_busy && spi_start) begin
      acc_cnt++;
      chk("spi_start_expected", int'(exp_spi.size() != 0), 1);
      if (exp_spi.size() != 0) begin
        eng_e = exp_spi.pop_front();
        chk("spi_din", int'(spi_din), int'(eng_e[7:0]));
        eng_val <= fixed_rx ? 8'hA5 : 8'($urandom);
        exp_rx.push_back({eng_e[8], fixed_rx ? 8'hA5 : 8'($urandom)});
      end
      eng_busy <= 1'b1;
      eng_cnt  <= 3'($urandom_range(4, 1));
    end else if (eng_busy) begin
      if (eng_cnt == 3'd0) begin
        eng_busy <= 1'b0;
        spi_dout <= exp_rx.size() != 0 ? exp_rx[$][7:0] : 8'h00;
      end else eng_cnt <= eng_cnt - 3'd1;
    end
  end

  // monitor: invariants, arbitration reference, guard time, done/rx scoreboard
  logic [1:0] r_s, g_prev;
  bit         last_m, after_rst, w, ew;
  int         hi_cnt;
  logic [8:0] mon_e;
  initial begin
    g_prev = 0; last_m = 1; after_rst = 1; hi_cnt = 0;
    forever begin
      @(posedge clk);
      r_s = req;
      #1;
      if (rst) begin
        g_prev = 0; last_m = 1; after_rst = 1; hi_cnt = 0;
      end else begin
        chk("cs_vs_gnt", int'(cs), int'(gnt == 2'b00));
        chk("busy_done_owner", int'((busy | done) & ~gnt), 0);
        if (gnt != 2'b00 && g_prev == 2'b00) begin
          w  = gnt[1];
          ew = (r_s == 2'b11) ? !last_m : r_s[1];
          chk("grant_winner", int'(w), int'(ew));
          chk("guard_time", int'(hi_cnt >= (after_rst ? CSH : CSH + 1)), 1);
          last_m = w; after_rst = 0;
          gnt_log.push_back(w);
        end
        hi_cnt = cs ? hi_cnt + 1 : 0;
        if (done != 2'b00) begin
          done_cnt++;
          chk("done_expected", int'(exp_rx.size() != 0), 1);
          if (exp_rx.size() != 0) begin
            mon_e = exp_rx.pop_front();
            chk("done_who", int'(done), mon_e[8] ? 2 : 1);
            chk("rx_data", int'(rx_data), int'(mon_e[7:0]));
          end
        end
        g_prev = gnt;
      end
    end
  end

  // one whole transaction for requester n; always starts and ends on a negedge
  task automatic txn(input int n, input int nbytes, input bit drop_mid, input bit fixed);
    int t;
    req[n] = 1'b1;
    t = 0;
    while (!gnt[n] && t < 3000) begin @(negedge clk); t++; end
    chk("gnt_wait", int'(gnt[n]), 1);
    for (int b = 0; b < nbytes && gnt[n]; b++) begin
      din[n] = fixed ? (b == 0 ? FAST_READ : 8'h00) : 8'($urandom);
      start[n] = 1'b1;
      exp_spi.push_back({1'(n), din[n]});
      @(negedge clk);
      start[n] = 1'b0;
      t = 0;
      if (drop_mid && b == nbytes - 1) begin
        while (!(spi_busy && !spi_start) && t < 200) begin @(negedge clk); t++; end
        req[n] = 1'b0;
      end
      while (!done[n] && t < 200) begin @(negedge clk); t++; end
      chk("done_wait", int'(done[n]), 1);
    end
    req[n] = 1'b0;
    @(negedge clk);
    chk("release_cs", int'(cs), 1);
    chk("release_gnt", int'(gnt[n]), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int a0, d0;
  bit exp_order [4] = '{0, 1, 0, 1};
  initial begin
    rst = 1; req = 0; start = 0; din[0] = 0; din[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", int'(cs), 1);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy_done", int'({busy, done}), 0);
    chk("rst_spi_start", int'(spi_start), 0);
    chk("rst_spi_din", int'(spi_din), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    rst = 0;
    // tie out of reset, then both re-request
    fork txn(0, 2, 0, 0); txn(1, 2, 0, 0); join
    fork txn(0, 2, 0, 0); txn(1, 2, 0, 0); join
    chk("order_len", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("order", int'(gnt_log[i]), int'(exp_order[i]));
    // single FAST_READ transaction with fixed engine data
    fixed_rx = 1; a0 = acc_cnt; d0 = done_cnt;
    txn(0, 4, 0, 1);
    chk("single_starts", acc_cnt - a0, 4);
    chk("single_dones", done_cnt - d0, 4);
    fixed_rx = 0;
    // guard: r1 asks as r0 releases
    fork
      txn(0, 1, 0, 0);
      begin
        while (!gnt[0]) @(negedge clk);
        while (req[0]) @(negedge clk);
        txn(1, 1, 0, 0);
      end
    join
    // non-owner starts are ignored
    a0 = acc_cnt;
    fork
      txn(0, 3, 0, 0);
      begin
        while (!gnt[0]) @(negedge clk);
        repeat (6) begin
          din[1] = 8'($urandom); start[1] = 1'b1;
          @(negedge clk); start[1] = 1'b0;
          @(negedge clk);
        end
      end
    join
    chk("nonowner_starts", acc_cnt - a0, 3);
    // request dropped mid-byte
    txn(0, 2, 1, 0);
    // randomized traffic
    for (int i = 0; i < 16; i++) begin
      automatic bit u0 = 1'($urandom), u1 = 1'($urandom);
      automatic int q0 = $urandom_range(3), q1 = $urandom_range(3);
      automatic int n0 = $urandom_range(4, 1), n1 = $urandom_range(4, 1);
      automatic bit x0 = 1'($urandom), x1 = 1'($urandom);
      fork
        if (u0) begin repeat (q0) @(negedge clk); txn(0, n0, x0, 0); end
        if (u1) begin repeat (q1) @(negedge clk); txn(1, n1, x1, 0); end
      join
      @(negedge clk);
    end
    // asynchronous reset while a byte is in flight
    req[0] = 1'b1;
    while (!gnt[0]) @(negedge clk);
    din[0] = 8'h5A; start[0] = 1'b1;
    exp_spi.push_back({1'b0, 8'h5A});
    @(negedge clk); start[0] = 1'b0;
    while (!spi_busy) @(negedge clk);
    chk("pre_rst_cs", int'(cs), 0);
    #2 rst = 1;
    #1;
    chk("async_rst_cs", int'(cs), 1);
    chk("async_rst_gnt", int'(gnt[0]), 0);
    req[0] = 1'b0;
    exp_spi.delete(); exp_rx.delete();
    @(negedge clk); @(negedge clk);
    rst = 0;
    fork
      txn(1, 2, 0, 0);
      repeat (CSH) begin @(negedge clk); chk("post_rst_no_gnt", int'(gnt), 0); end
    join
    chk("exp_spi_empty", exp_spi.size(), 0);
    chk("exp_rx_empty", exp_rx.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
- Shares the single byte-level SPI master engine and the flash chip select between two requesters.
  - Requester 0 is the NES ROM loader.
  - Requester 1 is the save/debug flash reader.
- Grants whole transactions: one CS-low window per grant, round-robin between requesters.
- Forwards byte starts to the engine and returns each received byte with a one-cycle done pulse.
- Enforces a minimum CS-high deselect time between transactions.
- Sits between the requesters and the spi engine instance; drives the flash cs pin directly.

Parameters:
- CS_HIGH_MIN, 4: minimum cycles cs is held high after a transaction before the next grant (range 1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- r0_req  in  1  requester 0 wants the flash; held high for the whole transaction.
- r0_gnt  out  1  requester 0 owns the flash and cs is low.
- r0_start  in  1  one-cycle byte start; sampled only when r0_gnt=1 and r0_busy=0.
- r0_din  in  8  byte to shift out, sampled with r0_start.
- r0_busy  out  1  requester 0 byte in flight.
- r0_done  out  1  one-cycle pulse: byte finished; rx_data is valid.
- r1_req, r1_gnt, r1_start, r1_din, r1_busy, r1_done: same as requester 0, for requester 1.
- rx_data  out  8  last received byte, shared; valid from the done pulse until the next done.
- spi_start  out  1  start to spi engine.
- spi_din  out  8  byte to spi engine.
- spi_busy  in  1  spi engine busy.
- spi_dout  in  8  spi engine received byte.
- cs  out  1  flash chip select, active-low.

Behaviour:
- Reset (async, rst=1) values:
  - cs=1; all gnt, busy, done and spi_start = 0; spi_din=0; rx_data=0.
  - state=GUARD with the guard counter loaded to CS_HIGH_MIN.
  - last_owner=1, so requester 0 wins the first tie.
- All outputs are registered.
- States:
  - GUARD: cs=1; counter decrements each cycle; at 0 → IDLE. Requests are ignored but not lost.
  - IDLE: if exactly one req is high, grant it. If both are high, grant the one != last_owner. On grant: owner<=n, last_owner<=n, cs<=0, rn_gnt<=1, → OWN. gnt and cs change in the same cycle.
  - OWN:
    - if rn_req=0 → gnt<=0, cs<=1, counter<=CS_HIGH_MIN, → GUARD;
    - else if rn_start=1 → spi_din<=rn_din, spi_start<=1, rn_busy<=1, → WAIT_HI.
  - WAIT_HI: hold spi_start=1 until spi_busy=1, then spi_start<=0 → WAIT_LO.
  - WAIT_LO: when spi_busy=0 → rx_data<=spi_dout, rn_done<=1 for one cycle, rn_busy<=0, → OWN.
- Earliest next start is the cycle after done; back-to-back bytes need no idle cycle on the requester side.
- Non-owner rn_start is ignored, and its done/busy stay 0.
- Owner start while busy is ignored.
- Owner drops req during WAIT_HI/WAIT_LO: the byte completes and done still pulses. OWN then sees req=0 and releases; gnt stays 1 until then.
- No preemption: the non-owner waits however long the owner holds req. Fairness holds per transaction only.
- Entering IDLE with spi_busy=1 is impossible by construction; no check needed.
- Reset mid-transfer: cs goes high immediately (async) and the grant is lost. The spi engine is reset by the same rst. Requesters must re-request.
- The CS_HIGH_MIN counter is 8 bits wide.

Decomposition:
- Shared package holds:
  - state encodings GUARD, IDLE, OWN, WAIT_HI, WAIT_LO (3 bits);
  - OWNER_R0=0 and OWNER_R1=1;
  - flash command constants (FAST_READ=8'h0B) used by both requesters.
- No sub-module; the single FSM plus the guard counter stays flat (~180 lines).

Test Plan:
- Single transaction:
  - Stimulus: r0_req=1 after reset guard; 4 starts with bytes 0x0B,0x00,0x00,0x00; engine model returns 0xA5 on each byte; then req drops.
  - Required: exactly 4 spi_start handshakes, each spi_din matching in order; 4 r0_done pulses with rx_data=0xA5; cs low for the whole window; cs high within 1 cycle after r0_req drop is sampled.
- Tie and round robin:
  - Stimulus: r0_req and r1_req high in the same cycle out of reset; each does 2-byte transactions, then both re-request.
  - Required: grant order r0, r1, r0, r1.
- Guard time:
  - Stimulus: CS_HIGH_MIN=4; r1_req raised the cycle r0 releases.
  - Required: cs high for ≥4 cycles; r1_gnt rises no earlier than 5 cycles after cs rose.
- Non-owner start:
  - Stimulus: r1_start pulsed while r0 owns.
  - Required: no spi_start; r1_done and r1_busy stay 0.
- Request dropped mid-byte:
  - Stimulus: r0_req falls while WAIT_LO.
  - Required: r0_done still pulses with the correct rx_data; cs rises after the done cycle.
- Reset mid-transfer:
  - Stimulus: rst asserted while spi_busy=1.
  - Required: cs=1 and r0_gnt=0 with no clock edge; after rst release, no grant for CS_HIGH_MIN cycles.
